// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the MIPS execute-stage ALU and the decode stage:
// data width, the 4-bit opcode type and its encodings, and the shift-mode
// selector used by the optional barrel shifter.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int unsigned ALU_DW = 32;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_OP_NOP  = 4'h0;
  localparam alu_op_t ALU_OP_ADD  = 4'h1;
  localparam alu_op_t ALU_OP_SUB  = 4'h2;
  localparam alu_op_t ALU_OP_AND  = 4'h3;
  localparam alu_op_t ALU_OP_OR   = 4'h4;
  localparam alu_op_t ALU_OP_XOR  = 4'h5;
  localparam alu_op_t ALU_OP_NOR  = 4'h6;
  localparam alu_op_t ALU_OP_SLT  = 4'h7;
  localparam alu_op_t ALU_OP_SLTU = 4'h8;
  localparam alu_op_t ALU_OP_SLL  = 4'h9;
  localparam alu_op_t ALU_OP_SRL  = 4'hA;
  localparam alu_op_t ALU_OP_SRA  = 4'hB;
  localparam alu_op_t ALU_OP_LUI  = 4'hC;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// ---------------------------------------------------------------------------
// alu_shifter
// 32-bit barrel shifter for SLL / SRL / SRA. Built as five log-stages so the
// shift amount bits each steer one mux level.
// Only present when ALU_SHIFT_EN is defined.
//
// Ports:
//   value_i  in  32  value to shift
//   shamt_i  in  5   shift amount
//   mode_i   in  2   SH_SLL / SH_SRL / SH_SRA
//   result_o out 32  shifted value
// ---------------------------------------------------------------------------
`ifdef ALU_SHIFT_EN
module alu_shifter
  import alu_pkg::*;
(
  input  logic [ALU_DW-1:0] value_i,
  input  logic [4:0]        shamt_i,
  input  shift_mode_e       mode_i,
  output logic [ALU_DW-1:0] result_o
);

  logic [ALU_DW-1:0] stage [0:5];
  logic              fill;

  // Right shifts are done in place; left shift reverses bits before and after
  // so one right-shifting datapath serves all three modes.
  function automatic logic [ALU_DW-1:0] bitrev(input logic [ALU_DW-1:0] v);
    logic [ALU_DW-1:0] r;
    for (int i = 0; i < ALU_DW; i++) r[i] = v[ALU_DW-1-i];
    return r;
  endfunction

  always_comb begin
    fill     = (mode_i == SH_SRA) ? value_i[ALU_DW-1] : 1'b0;
    stage[0] = (mode_i == SH_SLL) ? bitrev(value_i) : value_i;
    for (int s = 0; s < 5; s++) begin
      if (shamt_i[s])
        stage[s+1] = (stage[s] >> (1 << s)) |
                     ({ALU_DW{fill}} & ~({ALU_DW{1'b1}} >> (1 << s)));
      else
        stage[s+1] = stage[s];
    end
    result_o = (mode_i == SH_SLL) ? bitrev(stage[5]) : stage[5];
  end

endmodule
`endif

// File: rtl/mips_alu.sv
// ---------------------------------------------------------------------------
// mips_alu
// Combinational 32-bit MIPS ALU with zero and signed-overflow flags and a
// sticky overflow register for exception/debug reporting.
//
// Build option: ALU_SHIFT_EN -- when defined, the barrel shifter is built and
// opcodes SLL/SRL/SRA are implemented; otherwise they behave as reserved.
//
// Ports:
//   clk        in  1   clock for the sticky-overflow register
//   rst_n      in  1   synchronous active-low reset
//   op         in  4   operation code (alu_pkg::ALU_OP_*)
//   a          in  32  operand A, shift amount in a[4:0]
//   b          in  32  operand B, shifted value for shift ops
//   ovf_clr    in  1   synchronous clear of ovf_sticky (wins over set)
//   result     out 32  combinational result
//   zero       out 1   result == 0
//   overflow   out 1   signed overflow of ADD/SUB
//   ovf_sticky out 1   registered OR-accumulation of overflow
// ---------------------------------------------------------------------------
module mips_alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        op,
  input  logic [ALU_DW-1:0] a,
  input  logic [ALU_DW-1:0] b,
  input  logic              ovf_clr,
  output logic [ALU_DW-1:0] result,
  output logic              zero,
  output logic              overflow,
  output logic              ovf_sticky
);

  alu_op_t           op_w;
  logic              is_sub;
  logic [ALU_DW-1:0] b_add;
  logic [ALU_DW:0]   sum;
  logic              sum_ovf;
  logic              slt_bit;
  logic              sltu_bit;
  logic              ovf_sticky_q;
  logic              ovf_sticky_d;

  assign op_w = alu_op_t'(op);

  // One shared adder: subtract-type ops invert b and inject carry-in.
  always_comb begin
    is_sub = (op_w == ALU_OP_SUB) || (op_w == ALU_OP_SLT) || (op_w == ALU_OP_SLTU);
    b_add  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_add} + {{ALU_DW{1'b0}}, is_sub};
    // Same formula covers add and subtract because b_add is already inverted.
    sum_ovf  = (a[ALU_DW-1] == b_add[ALU_DW-1]) && (sum[ALU_DW-1] != a[ALU_DW-1]);
    // Sign of the true difference is the raw sign bit corrected by overflow.
    slt_bit  = sum[ALU_DW-1] ^ sum_ovf;
    // No carry out of a + ~b + 1 means a borrowed, i.e. a < b unsigned.
    sltu_bit = ~sum[ALU_DW];
  end

`ifdef ALU_SHIFT_EN
  shift_mode_e       sh_mode;
  logic [ALU_DW-1:0] sh_result;

  always_comb begin
    case (op_w)
      ALU_OP_SRL: sh_mode = SH_SRL;
      ALU_OP_SRA: sh_mode = SH_SRA;
      default:    sh_mode = SH_SLL;
    endcase
  end

  alu_shifter u_shifter (
    .value_i  (b),
    .shamt_i  (a[4:0]),
    .mode_i   (sh_mode),
    .result_o (sh_result)
  );
`endif

  always_comb begin
    result = '0;
    case (op_w)
      ALU_OP_ADD:  result = sum[ALU_DW-1:0];
      ALU_OP_SUB:  result = sum[ALU_DW-1:0];
      ALU_OP_AND:  result = a & b;
      ALU_OP_OR:   result = a | b;
      ALU_OP_XOR:  result = a ^ b;
      ALU_OP_NOR:  result = ~(a | b);
      ALU_OP_SLT:  result = {{(ALU_DW-1){1'b0}}, slt_bit};
      ALU_OP_SLTU: result = {{(ALU_DW-1){1'b0}}, sltu_bit};
`ifdef ALU_SHIFT_EN
      ALU_OP_SLL,
      ALU_OP_SRL,
      ALU_OP_SRA:  result = sh_result;
`endif
      ALU_OP_LUI:  result = {b[15:0], 16'h0000};
      default:     result = '0;
    endcase
  end

  assign zero     = (result == '0);
  assign overflow = ((op_w == ALU_OP_ADD) || (op_w == ALU_OP_SUB)) && sum_ovf;

  always_comb begin
    ovf_sticky_d = ovf_sticky_q | overflow;
    if (ovf_clr) ovf_sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_sticky_q <= 1'b0;
    else        ovf_sticky_q <= ovf_sticky_d;
  end

  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_mips_alu.sv
module tb_mips_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        ovf_clr;
  logic [31:0] result;
  logic        zero, overflow, ovf_sticky;

  always #5 clk = ~clk;

  mips_alu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .a          (a),
    .b          (b),
    .ovf_clr    (ovf_clr),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow),
    .ovf_sticky (ovf_sticky)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        o;
    string       name;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] r;
    logic        z;
    logic        o;
    logic        s;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_vec  = 0;
  int n_miss = 0;

  // Sticky model state, driven only by the stimulus process.
  logic m_sticky = 1'b0;
  logic prev_rst = 1'b0;
  logic prev_clr = 1'b0;
  logic prev_ovf = 1'b0;

  task automatic add_vec(input logic [3:0] o_, input logic [31:0] a_, input logic [31:0] b_,
                         input logic [31:0] r_, input logic z_, input logic ov_, input string n_);
    vec_t v;
    v.op = o_; v.a = a_; v.b = b_; v.r = r_; v.z = z_; v.o = ov_; v.name = n_;
    vecs.push_back(v);
  endtask

  // Drive one cycle of stimulus just after the rising edge and queue what the
  // outputs must show at the following falling edge.
  task automatic drive(input logic [3:0] o_, input logic [31:0] a_, input logic [31:0] b_,
                       input logic clr_, input logic rstn_,
                       input logic [31:0] r_, input logic z_, input logic ov_, input string n_);
    exp_t e;
    @(posedge clk);
    if (!prev_rst)     m_sticky = 1'b0;
    else if (prev_clr) m_sticky = 1'b0;
    else               m_sticky = m_sticky | prev_ovf;
    #1;
    op = o_; a = a_; b = b_; ovf_clr = clr_; rst_n = rstn_;
    e.name = n_; e.r = r_; e.z = z_; e.o = ov_; e.s = m_sticky;
    sb.push_back(e);
    prev_rst = rstn_; prev_clr = clr_; prev_ovf = ov_;
  endtask

  function automatic void model(input logic [3:0] o_, input logic [31:0] a_, input logic [31:0] b_,
                                output logic [31:0] r_, output logic ov_);
    longint sa, sbv, s;
    sa  = longint'($signed(a_));
    sbv = longint'($signed(b_));
    r_  = 32'h0;
    ov_ = 1'b0;
    case (o_)
      4'h1: begin s = sa + sbv; r_ = a_ + b_; ov_ = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'h2: begin s = sa - sbv; r_ = a_ - b_; ov_ = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'h3: r_ = a_ & b_;
      4'h4: r_ = a_ | b_;
      4'h5: r_ = a_ ^ b_;
      4'h6: r_ = ~(a_ | b_);
      4'h7: r_ = (sa < sbv) ? 32'd1 : 32'd0;
      4'h8: r_ = (a_ < b_) ? 32'd1 : 32'd0;
      4'hC: r_ = {b_[15:0], 16'h0};
      default: r_ = 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (result !== e.r) begin
        n_miss++; $display("FAIL %s result: got %h expected %h", e.name, result, e.r);
      end
      if (zero !== e.z) begin
        n_miss++; $display("FAIL %s zero: got %b expected %b", e.name, zero, e.z);
      end
      if (overflow !== e.o) begin
        n_miss++; $display("FAIL %s overflow: got %b expected %b", e.name, overflow, e.o);
      end
      if (ovf_sticky !== e.s) begin
        n_miss++; $display("FAIL %s ovf_sticky: got %b expected %b", e.name, ovf_sticky, e.s);
      end
    end
  end

  initial begin
    logic [31:0] rr;
    logic        ro;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic        rclr;
    logic [3:0]  ops [7];

    rst_n = 1'b0; op = 4'h0; a = '0; b = '0; ovf_clr = 1'b0;

    add_vec(4'h1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, "add_ovf");
    add_vec(4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, "nop_after_ovf");
    add_vec(4'h2, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, "sub_zero");
    add_vec(4'h2, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, "sub_ovf");
    add_vec(4'h2, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, "sub_ovf_pos");
    add_vec(4'h1, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, "add_ovf_neg");
    add_vec(4'h1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, "add_wrap");
    add_vec(4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, "slt_neg");
    add_vec(4'h8, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, "sltu_big");
    add_vec(4'h7, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, "slt_ovf_case");
    add_vec(4'h7, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, "slt_ovf_rev");
    add_vec(4'h8, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, "sltu_small");
    add_vec(4'h3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, "and");
    add_vec(4'h4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, "or");
    add_vec(4'h5, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0, "xor");
    add_vec(4'h6, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 1'b0, 1'b0, "nor");
`ifdef ALU_SHIFT_EN
    add_vec(4'h9, 32'h00000004, 32'h80000001, 32'h00000010, 1'b0, 1'b0, "sll4");
    add_vec(4'hA, 32'h00000004, 32'h80000001, 32'h08000000, 1'b0, 1'b0, "srl4");
    add_vec(4'hB, 32'h00000004, 32'h80000001, 32'hF8000000, 1'b0, 1'b0, "sra4");
    add_vec(4'hB, 32'h00000020, 32'h80000001, 32'h80000001, 1'b0, 1'b0, "sra_sh0");
    add_vec(4'h9, 32'hFFFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, "sll31");
    add_vec(4'hA, 32'h0000001F, 32'h80000000, 32'h00000001, 1'b0, 1'b0, "srl31");
    add_vec(4'hB, 32'h0000001F, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, "sra31");
`else
    add_vec(4'h9, 32'h00000004, 32'h80000001, 32'h00000000, 1'b1, 1'b0, "sll4_off");
    add_vec(4'hA, 32'h00000004, 32'h80000001, 32'h00000000, 1'b1, 1'b0, "srl4_off");
    add_vec(4'hB, 32'h00000004, 32'h80000001, 32'h00000000, 1'b1, 1'b0, "sra4_off");
    add_vec(4'hB, 32'h00000020, 32'h80000001, 32'h00000000, 1'b1, 1'b0, "sra_sh0_off");
`endif
    add_vec(4'hC, 32'hFFFFFFFF, 32'h00001234, 32'h12340000, 1'b0, 1'b0, "lui");
    add_vec(4'h0, 32'hDEADBEEF, 32'hCAFEF00D, 32'h00000000, 1'b1, 1'b0, "nop");
    add_vec(4'hD, 32'hDEADBEEF, 32'hCAFEF00D, 32'h00000000, 1'b1, 1'b0, "rsv_d");
    add_vec(4'hE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, "rsv_e");
    add_vec(4'hF, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, "rsv_f");

    // Reset held while overflow is present: sticky must stay 0.
    drive(4'h1, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, "rst_ovf0");
    drive(4'h1, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, "rst_ovf1");
    drive(4'h1, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, "rst_ovf2");
    drive(4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, "rst_release");
    drive(4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, "idle");

    foreach (vecs[i])
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b1,
            vecs[i].r, vecs[i].z, vecs[i].o, vecs[i].name);

    // Clear alone, then clear colliding with a fresh overflow, then re-arm.
    drive(4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, "clr_pulse");
    drive(4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, "after_clr");
    drive(4'h1, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, "set_again");
    drive(4'h1, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b1, 32'h80000000, 1'b0, 1'b1, "clr_vs_ovf");
    drive(4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, "clr_won");
    drive(4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, "clr_held");

    ops = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h7, 4'h8, 4'hC};
    for (int i = 0; i < 60; i++) begin
      rop  = ops[$urandom_range(0, 6)];
      ra   = $urandom;
      rb   = $urandom;
      if (i % 5 == 0) rb = ra;
      if (i % 7 == 0) ra = {1'b0, ra[30:0]};
      rclr = ($urandom_range(0, 3) == 0);
      model(rop, ra, rb, rr, ro);
      drive(rop, ra, rb, rclr, 1'b1, rr, (rr == 32'h0), ro, "rand");
    end
    drive(4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, "final");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
